// File: rtl/axi_pkg.sv
// Shared AXI constants and the read-master FSM state type.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    // Beats wider than 4 bytes are not supported by the data path.
    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return (size > 3'd2) ? 3'd2 : size;
    endfunction

endpackage

// File: rtl/axi_r_master.sv
// AXI4 read-channel master: one core burst request -> one AR transfer -> R beats
// returned through a one-entry registered response port.
//
// state | meaning
// IDLE  | waiting for a core request, req_ready high
// ADDR  | ARVALID held with stable AR* until ARREADY
// DATA  | collecting R beats until RLAST or beat count reaches ARLEN
module axi_r_master
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]            req_len,
    input  logic [2:0]            req_size,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  rsp_err,
    input  logic                  rsp_ready,
    output logic                  busy
);

    state_t     state, state_nxt;
    logic [7:0] beat_cnt;
    logic       req_take, ar_done, beat;
    logic       len_hit, beat_last, beat_err;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign ARBURST   = AXI_BURST_INCR;
    assign RREADY    = (state == DATA) && (!rsp_valid || rsp_ready);

    assign req_take  = req_valid && req_ready;
    assign ar_done   = ARVALID && ARREADY;
    assign beat      = RVALID && RREADY;
    assign len_hit   = (beat_cnt == ARLEN);
    assign beat_last = RLAST || len_hit;
    // RLAST disagreeing with the length count covers both early and missing last.
    assign beat_err  = (RRESP != AXI_RESP_OKAY) || (RLAST != len_hit);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_take) state_nxt = ADDR;
            ADDR:    if (ar_done) state_nxt = DATA;
            DATA:    if (beat && beat_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ARADDR   <= '0;
            ARLEN    <= '0;
            ARSIZE   <= '0;
            ARVALID  <= 1'b0;
            beat_cnt <= '0;
        end else begin
            if (req_take) begin
                ARADDR   <= req_addr;
                ARLEN    <= req_len;
                ARSIZE   <= clamp_size(req_size);
                ARVALID  <= 1'b1;
                beat_cnt <= '0;
            end else begin
                if (ar_done) ARVALID <= 1'b0;
                if (beat) beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
        end else if (beat) begin
            rsp_valid <= 1'b1;
            rsp_data  <= RDATA;
            rsp_last  <= beat_last;
            rsp_err   <= beat_err;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_r_master.sv
// Randomized bench for axi_r_master: a TB-side R slave plan plus a one-entry
// response model predict every AR field, RREADY, and every returned beat.
module tb_axi_r_master;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [2:0]  req_size;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;
    logic        rsp_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    axi_r_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_len(req_len), .req_size(req_size),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .rsp_err(rsp_err), .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_araddr", ARADDR, 0);
        chk("rst_arlen", ARLEN, 0);
        chk("rst_arsize", ARSIZE, 0);
        chk("rst_rready", RREADY, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_last", rsp_last, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 1);
    endtask

    // One burst. early>=0 makes the slave raise RLAST on that beat; drop_last
    // makes it never raise RLAST (and then send stray beats); rst_at>=0 pulses
    // reset once that many beats have been accepted.
    task automatic do_burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                            input int early, input bit drop_last, input int ar_wait,
                            input bit allow_err, input int ready_mode,
                            input logic [31:0] d0, input logic [1:0] resp0, input int rst_at);
        logic [31:0] pdata [256];
        logic [1:0]  presp [256];
        logic [2:0]  exp_size;
        int          endi, nbeats, sent, popped, cyc, idx;
        bit          in_data, mvalid, exp_rr, mismatch_end;

        endi         = (early >= 0 && early < int'(l)) ? early : int'(l);
        nbeats       = endi + 1;
        mismatch_end = (endi != int'(l)) || drop_last;
        exp_size     = (s > 3'd2) ? 3'd2 : s;
        for (int i = 0; i < nbeats; i++) begin
            pdata[i] = $urandom;
            presp[i] = (allow_err && $urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        end
        if (d0 != 0) pdata[0] = d0;
        if (resp0 != 0) presp[0] = resp0;

        req_valid = 1'b1; req_addr = a; req_len = l; req_size = s;
        #1;
        chk("req_ready_idle", req_ready, 1);
        @(negedge ACLK);
        req_valid = 1'b0; req_addr = $urandom; req_len = 8'($urandom); req_size = 3'($urandom);

        for (int w = 0; w <= ar_wait; w++) begin
            ARREADY = (w == ar_wait);
            #1;
            chk("arvalid", ARVALID, 1);
            chk("araddr", ARADDR, a);
            chk("arlen", ARLEN, l);
            chk("arsize", ARSIZE, exp_size);
            chk("arburst", ARBURST, 2'b01);
            chk("rready_addr", RREADY, 0);
            chk("busy_addr", busy, 1);
            chk("req_ready_addr", req_ready, 0);
            @(negedge ACLK);
        end
        ARREADY = 1'b0;
        #1;
        chk("arvalid_drop", ARVALID, 0);

        in_data = 1; sent = 0; popped = 0; mvalid = 0; cyc = 0;
        while (popped < nbeats && cyc < 2000) begin
            if (rst_at >= 0 && sent == rst_at) begin
                RVALID = 1'b1;
                ARESET = 1'b1;
                #1;
                chk_reset_outputs();
                @(negedge ACLK);
                #1;
                chk_reset_outputs();
                ARESET = 1'b0;
                RVALID = 1'b0;
                @(negedge ACLK);
                #1;
                chk("rready_after_rst", RREADY, 0);
                chk("arvalid_after_rst", ARVALID, 0);
                return;
            end
            idx    = (sent < nbeats) ? sent : 0;
            RVALID = (sent < nbeats) ? ($urandom_range(0, 3) != 0) : drop_last;
            RDATA  = (sent < nbeats) ? pdata[idx] : $urandom;
            RRESP  = (sent < nbeats) ? presp[idx] : 2'b00;
            RLAST  = (sent < nbeats) && !drop_last && (sent == endi);
            case (ready_mode)
                0:       rsp_ready = ($urandom_range(0, 2) != 0);
                1:       rsp_ready = cyc[0];
                default: rsp_ready = 1'b1;
            endcase
            #1;
            exp_rr = in_data && (!mvalid || rsp_ready);
            chk("rready", RREADY, exp_rr);
            chk("busy", busy, in_data);
            chk("req_ready", req_ready, !in_data);
            chk("rsp_valid", rsp_valid, mvalid);
            if (mvalid && rsp_ready) begin
                chk("rsp_data", rsp_data, pdata[popped]);
                chk("rsp_last", rsp_last, popped == endi);
                chk("rsp_err", rsp_err, (presp[popped] != 2'b00) || (popped == endi && mismatch_end));
                popped++;
            end
            if (RVALID && exp_rr) begin
                mvalid = 1;
                sent++;
                if (sent == nbeats) in_data = 0;
            end else if (rsp_ready) begin
                mvalid = 0;
            end
            @(negedge ACLK);
            cyc++;
        end
        chk("burst_timeout", popped, nbeats);
        RVALID = 1'b0; RLAST = 1'b0; rsp_ready = 1'b0;
        #1;
        chk("busy_end", busy, 0);
        chk("rsp_valid_end", rsp_valid, 0);
    endtask

    initial begin
        int l, e;
        bit dl;
        ARESET = 1'b1;
        req_valid = 0; req_addr = 0; req_len = 0; req_size = 0;
        ARREADY = 0; RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0; rsp_ready = 0;
        repeat (2) @(negedge ACLK);
        #1;
        chk_reset_outputs();
        ARESET = 1'b0;
        @(negedge ACLK);

        do_burst(32'h100, 8'd0, 3'd2, -1, 0, 0, 0, 2, 32'hDEADBEEF, 2'b00, -1);
        do_burst(32'h40,  8'd3, 3'd2, -1, 0, 0, 0, 1, 32'h0, 2'b00, -1);
        do_burst(32'h80,  8'd2, 3'd6, -1, 0, 5, 0, 0, 32'h0, 2'b00, -1);
        do_burst(32'hC0,  8'd3, 3'd2,  1, 0, 0, 0, 2, 32'h0, 2'b00, -1);
        do_burst(32'h200, 8'd1, 3'd1, -1, 0, 0, 0, 2, 32'h0, 2'b10, -1);
        do_burst(32'h300, 8'd2, 3'd0, -1, 1, 1, 0, 2, 32'h0, 2'b00, -1);
        do_burst(32'h400, 8'd7, 3'd2, -1, 0, 0, 0, 2, 32'h0, 2'b00, 2);
        do_burst(32'h500, 8'd0, 3'd2, -1, 0, 0, 0, 2, 32'h0, 2'b00, -1);

        for (int n = 0; n < 30; n++) begin
            l  = $urandom_range(0, 15);
            e  = (l > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, l - 1) : -1;
            dl = (e < 0) && ($urandom_range(0, 4) == 0);
            do_burst($urandom, 8'(l), 3'($urandom_range(0, 7)), e, dl,
                     $urandom_range(0, 3), 1, $urandom_range(0, 2), 32'h0, 2'b00, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
